// File: rtl/lsu.sv
// lsu: load/store unit between the memory stage and the byte-addressed data_mem.
// Optional feature macro LSU_MISALIGN_SPLIT_EN: misaligned in-range H/W accesses run as byte beats.
module lsu #(
  parameter int MEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  resp_cause,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [2:0]  mem_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [32:0] MEM_LIMIT    = 33'(MEM_BYTES);
  localparam logic [1:0]  CAUSE_NONE   = 2'b00;
  localparam logic [1:0]  CAUSE_ACCESS = 2'b10;
  localparam logic [1:0]  CAUSE_ILLEGAL = 2'b11;
  localparam logic [2:0]  MT_B  = 3'b000;
  localparam logic [2:0]  MT_H  = 3'b001;
  localparam logic [2:0]  MT_W  = 3'b010;
  localparam logic [2:0]  MT_BU = 3'b011;
  localparam logic [2:0]  MT_HU = 3'b100;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [1:0]  cause_q, cause_d;
  logic        last_beat;

  // Request decode, evaluated on the live request bus in IDLE
  logic        dec_legal;
  logic [2:0]  dec_type;
  logic [32:0] dec_size;
  logic        dec_oor;
  logic        dec_misaligned;
  logic        dec_fault;
  logic [1:0]  dec_cause;

  always_comb begin
    dec_legal = 1'b1;
    dec_type  = MT_B;
    case (req_funct3)
      3'b000:  dec_type = MT_B;
      3'b001:  dec_type = MT_H;
      3'b010:  dec_type = MT_W;
      3'b100: begin
        dec_type  = MT_BU;
        dec_legal = !req_we;
      end
      3'b101: begin
        dec_type  = MT_HU;
        dec_legal = !req_we;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   dec_size = 33'd1;
      2'b01:   dec_size = 33'd2;
      default: dec_size = 33'd4;
    endcase
    // 33-bit sum so an address near 2^32 cannot wrap back into range
    dec_oor        = ({1'b0, req_addr} + dec_size) > MEM_LIMIT;
    dec_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    dec_fault = 1'b1;
    dec_cause = CAUSE_ILLEGAL;
    if (!dec_legal) begin
      dec_cause = CAUSE_ILLEGAL;
    end else if (dec_oor) begin
      dec_cause = CAUSE_ACCESS;
`ifdef LSU_MISALIGN_SPLIT_EN
    end else begin
      dec_fault = 1'b0;
      dec_cause = CAUSE_NONE;
    end
`else
    end else if (dec_misaligned) begin
      dec_cause = 2'b01;
    end else begin
      dec_fault = 1'b0;
      dec_cause = CAUSE_NONE;
    end
`endif
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  logic        split_q, split_d;
  logic [1:0]  beat_q, beat_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] asm_next;
  logic [31:0] asm_ext;
  logic [1:0]  last_idx;

  assign last_idx  = (type_q == MT_W) ? 2'd3 : 2'd1;
  assign last_beat = !split_q || (beat_q == last_idx);

  always_comb begin
    asm_next = asm_q;
    asm_next[{beat_q, 3'b000} +: 8] = mem_rdata[7:0];
    case (type_q)
      MT_H:    asm_ext = {{16{asm_next[15]}}, asm_next[15:0]};
      MT_HU:   asm_ext = {16'h0000, asm_next[15:0]};
      default: asm_ext = asm_next;
    endcase
  end
`else
  assign last_beat = 1'b1;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = dec_fault ? RESP : ACCESS;
      ACCESS:  if (last_beat) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs; memory enables drop in a reset cycle so an aborted beat never commits
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_rdata = resp_valid ? rdata_q : 32'h0;
    resp_err   = resp_valid && err_q;
    resp_cause = resp_valid ? cause_q : CAUSE_NONE;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    mem_type   = 3'b000;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    if ((state_q == ACCESS) && !rst) begin
      mem_rd_en = !we_q;
      mem_wr_en = we_q;
      mem_type  = type_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
`ifdef LSU_MISALIGN_SPLIT_EN
      if (split_q) begin
        mem_type  = we_q ? MT_B : MT_BU;
        mem_addr  = addr_q + {30'h0, beat_q};
        mem_wdata = {24'h0, wdata_q[{beat_q, 3'b000} +: 8]};
      end
`endif
    end
  end

  // Datapath next-state
  always_comb begin
    we_d    = we_q;
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cause_d = cause_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    split_d = split_q;
    beat_d  = beat_q;
    asm_d   = asm_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          type_d  = dec_type;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'h0;
          err_d   = dec_fault;
          cause_d = dec_cause;
`ifdef LSU_MISALIGN_SPLIT_EN
          split_d = dec_misaligned && !dec_fault;
          beat_d  = 2'd0;
          asm_d   = 32'h0;
`endif
        end
      end
      ACCESS: begin
`ifdef LSU_MISALIGN_SPLIT_EN
        beat_d = beat_q + 2'd1;
        if (!we_q) begin
          if (split_q) begin
            asm_d = asm_next;
            if (last_beat) rdata_d = asm_ext;
          end else begin
            rdata_d = mem_rdata;
          end
        end
`else
        if (!we_q) rdata_d = mem_rdata;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      type_q  <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cause_q <= CAUSE_NONE;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q <= 1'b0;
      beat_q  <= 2'd0;
      asm_q   <= 32'h0;
`endif
    end else begin
      we_q    <= we_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cause_q <= cause_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q <= split_d;
      beat_q  <= beat_d;
      asm_q   <= asm_d;
`endif
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the pipeline's memory stage and the byte-addressed `data_mem`. Accepts one load or store request at a time over a valid/ready handshake and decodes RISC-V `funct3` into the data memory's `mem_type` encoding. Checks the request for illegal width, out-of-range and misaligned addresses, drives the memory port for one or more cycles, and returns a single-cycle response with extended load data or an error cause.

## Interface
- `MEM_BYTES`, 32, number of addressable bytes in `data_mem`; the last legal byte address is `MEM_BYTES-1`.
- `clk`  in  1  clock; memory writes commit on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  LSU can accept; equals `state==IDLE`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, LSB-aligned.
- `resp_valid`  out  1  one-cycle response pulse; no backpressure.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  request faulted; no memory access was made.
- `resp_cause`  out  2  01 misaligned, 10 access fault, 11 illegal funct3, 00 none.
- `mem_rd_en`, `mem_wr_en`  out  1  to `data_mem` `rd_en`/`wr_en`.
- `mem_type`  out  3  to `data_mem`: 000 B signed, 001 H signed, 010 W, 011 BU, 100 HU.
- `mem_addr`, `mem_wdata`  out  32  to `data_mem`.
- `mem_rdata`  in  32  asynchronous read data from `data_mem`.

## Operation
- **States**
  - IDLE: ready for a request.
  - ACCESS: drives the memory port for one cycle per memory beat.
  - RESP: drives `resp_valid` high for exactly one cycle, then returns to IDLE.
- **Acceptance:** a request is accepted when `req_valid && req_ready` and `rst` is low. On acceptance, `req_*` is latched into registers. The pipeline may change `req_*` afterwards.
- **Funct3 mapping**
  - Loads: 000→000, 001→001, 010→010, 100→011, 101→100.
  - Stores: 000, 001, 010 map unchanged.
  - Any other combination is illegal.
- **Size:** n = 1, 2 or 4 bytes.
- **Checks at acceptance**, in priority order:
  1. illegal funct3 → cause 11;
  2. `{1'b0,addr}+n > MEM_BYTES` (33-bit compare) → cause 10;
  3. misaligned (H with `addr[0]`, W with `addr[1:0]!=0`) → cause 01, unless `LSU_MISALIGN_SPLIT_EN` is defined.
- **Faulting request:** IDLE→RESP directly. `mem_rd_en` and `mem_wr_en` are never asserted, `resp_err=1`, `resp_rdata=0`.
- **Aligned access:** one ACCESS beat using the mapped `mem_type`, `mem_addr=addr`, `mem_wdata=wdata`.
  - Loads capture `mem_rdata` at the end of ACCESS. The value is already extended by `data_mem`.
- **Memory outputs outside ACCESS:** `mem_rd_en=mem_wr_en=0`; `mem_addr`, `mem_wdata` and `mem_type` are 0.
- **Store response:** `resp_valid` with `resp_err=0`, `resp_rdata=0`.

## Timing
- **Reset** (effective at the clock edge where `rst=1`):
  - state→IDLE, all latched registers and the beat counter cleared.
  - Registered outputs after reset: `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `resp_cause=00`, memory enables 0, `req_ready=1`.
  - A request presented in a cycle with `rst=1` is ignored.
- **Aligned latency:** accept at cycle T, ACCESS at T+1 (a store commits at the end of T+1), `resp_valid` at T+2. A new request can be accepted at T+3.
- **Fault latency:** accept at T, `resp_valid` at T+1.
- **Split latency** (macro defined): ACCESS lasts T+1…T+n, `resp_valid` at T+n+1.
- **Back-to-back:** `req_ready` is 0 during ACCESS and RESP, so requests never overlap.
- **Reset mid-operation:** the FSM aborts immediately and no further memory enables are asserted.
  - Bytes of a split store already written stay written.
  - No response is issued for the aborted request.
- **Address arithmetic:** beat addresses `addr+k` never wrap, because the range check precedes any access.

## Configuration
- **`LSU_MISALIGN_SPLIT_EN` defined:** misaligned in-range H/W requests are legal and execute as n byte beats, k = 0…n-1.
  - Each beat uses `mem_addr=addr+k`.
  - Loads use `mem_type=011`. `mem_rdata[7:0]` goes into byte k of an assembly register.
  - Stores use `mem_type=000` with `mem_wdata={24'b0, wdata[8k+7:8k]}`.
  - In RESP, the assembled data is sign-extended for LH and zero-extended for LHU. LW is passed through.
  - Aligned requests still take a single beat.
- **Undefined:** misaligned requests fault with cause 01. No beat counter or assembly register is synthesized.

## Test plan
- SW addr 4 data 0xDEADBEEF (accept at T) → `mem_wr_en` only at T+1, `resp_valid` at T+2. Then LW 4 → `resp_rdata=0xDEADBEEF`, `resp_err=0`.
- SB addr 8 data 0x00000080 → LB 8 returns 0xFFFFFF80; LBU 8 returns 0x00000080. SH 10 data 0x8001 → LHU 10 returns 0x00008001.
- LH addr 3:
  - without macro → `resp_valid` at T+1, `resp_err=1`, cause 01, `mem_rd_en` never high.
  - with macro, after SB 3=0x34 and SB 4=0x92 → byte reads at 3 and 4, `resp_rdata=0xFFFF9234` at T+3.
- LW addr 30 with `MEM_BYTES=32` → cause 10, no memory enable. `req_funct3=011` load → cause 11, even at a misaligned out-of-range address.
- With macro: SW addr 1 data 0xAABBCCDD, with `rst` pulsed during the 3rd ACCESS beat → only bytes 1 and 2 written, no `resp_valid`, `req_ready=1` the cycle after the reset edge, memory enables 0.
- Handshake: hold `req_valid=1` continuously with 3 aligned loads → exactly 3 `resp_valid` pulses, one every 3 cycles, none dropped or duplicated.
